instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default `ADDRESS_WIDTH'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_valid  input  1  fetch result valid (from fetch o_res_valid).
REQ-006 SHALL have port i_instr  input  `MAX_INSTR_WIDTH  fetched instruction bits.
REQ-007 SHALL have port i_instr_len  input  4  instruction length in bytes.
REQ-008 SHALL have port i_fetch_ready  input  1  fetch can accept a new PC (from fetch o_ready).
REQ-009 SHALL have port o_fetch_valid  output  1  new PC offered to fetch (to fetch i_valid).
REQ-010 SHALL have port o_fetch_pc  output  `ADDRESS_WIDTH  PC offered to fetch (to fetch i_pc).
REQ-011 SHALL have port o_valid  output  1  head entry valid to decode.
REQ-012 SHALL have port o_instr  output  `MAX_INSTR_WIDTH  head instruction.
REQ-013 SHALL have port o_instr_len  output  4  head instruction length.
REQ-014 SHALL have port o_pc  output  `ADDRESS_WIDTH  head instruction address.
REQ-015 SHALL have port i_ready  input  1  decode accepts head entry.
REQ-016 SHALL have port i_redirect_valid  input  1  branch redirect request.
REQ-017 SHALL have port i_redirect_pc  input  `ADDRESS_WIDTH  redirect target.
REQ-018 SHALL have port o_full  output  1  count == DEPTH.
REQ-019 SHALL have port o_overflow  output  1  sticky: result dropped because full.
REQ-020 SHALL have port o_len_error  output  1  sticky: result with i_instr_len == 0 or > `MAX_INSTR_WIDTH/8.

Function
REQ-021 SHALL implement FSM states START, RUN, REDIRECT; reset enters START.
REQ-022 SHALL, in START and REDIRECT, assert o_fetch_valid with o_fetch_pc = pending PC; transfer when o_fetch_valid && i_fetch_ready, then next state RUN.
REQ-023 SHALL deassert o_fetch_valid in RUN.
REQ-024 SHALL, in RUN, push {i_instr, i_instr_len, running_pc} when i_valid, length legal, not full; running_pc += i_instr_len modulo 2^`ADDRESS_WIDTH.
REQ-025 SHALL drop results arriving in START or REDIRECT, including the transfer cycle (stale responses).
REQ-026 SHALL drop a full-queue result, set o_overflow, leave running_pc unchanged.
REQ-027 SHALL drop an illegal-length result, set o_len_error, leave running_pc unchanged.
REQ-028 SHALL pop head when o_valid && i_ready; o_valid = count != 0; outputs driven from head, zero-latency.
REQ-029 SHALL allow simultaneous push and pop when full; pop frees slot same cycle (count unchanged).
REQ-030 SHALL, on i_redirect_valid in any state, flush FIFO (count 0 next cycle), set pending PC and running_pc to i_redirect_pc, enter REDIRECT; redirect wins over same-cycle push/pop/transfer.
REQ-031 SHALL wrap read/write pointers modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-032 SHALL yield first push latency of one cycle: o_valid high the cycle after accepted i_valid.

Reset
REQ-033 SHALL on reset: state START, pending PC = running_pc = RESET_PC, count/pointers 0, o_valid 0, o_full 0, o_overflow 0, o_len_error 0; o_fetch_valid 1 from first post-reset cycle.
REQ-034 SHALL give reset priority over all inputs including i_redirect_valid; mid-operation reset discards queue contents.

Structure
REQ-035 SHALL take `ADDRESS_WIDTH, `MAX_INSTR_WIDTH, FSM state encodings from shared header.v.
REQ-036 SHALL place storage in one sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty).

Verification
REQ-037 Reset, i_fetch_ready=1 -> o_fetch_valid=1, o_fetch_pc=0 one cycle, then RUN, o_fetch_valid=0.
REQ-038 Results len 4,2,4 in RUN, i_ready=1 -> o_pc 0x0, 0x4, 0x6 in order, one cycle after each push.
REQ-039 i_ready=0, DEPTH=4, 5 results -> o_full=1 after 4th, 5th dropped, o_overflow=1, next o_pc correct.
REQ-040 Redirect 0x100 with 3 queued and same-cycle i_valid -> o_valid=0 next cycle, o_fetch_pc=0x100, stale result dropped, next pushed o_pc=0x100.
REQ-041 i_instr_len=0 -> no push, o_len_error=1, running_pc unchanged.
REQ-042 running_pc=all-ones-minus-1, len 4 -> next o_pc wraps to 0x2.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared definitions for the instruction queue: widths, FSM states, queue entry layout.
package instr_queue_pkg;

  localparam int ADDRESS_WIDTH   = 32;
  localparam int MAX_INSTR_WIDTH = 32;
  localparam int MAX_INSTR_BYTES = MAX_INSTR_WIDTH / 8;

  typedef enum logic [1:0] {
    START    = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } iq_state_e;

  typedef struct packed {
    logic [MAX_INSTR_WIDTH-1:0] instr;
    logic [3:0]                 len;
    logic [ADDRESS_WIDTH-1:0]   pc;
  } iq_entry_t;

  // A length is usable only if it is non-zero and fits in the instruction field.
  function automatic logic len_legal(input logic [3:0] len);
    return (len != 4'd0) && (int'(len) <= MAX_INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_queue_sync_fifo.sv
// Synchronous FIFO with flush; head data is visible combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array has no reset; occupancy is tracked by count, so stale contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: issues fetch PCs, tracks the running PC
// of returned instructions, and buffers them for decode. Redirects flush the queue.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int                       DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [MAX_INSTR_WIDTH-1:0] i_instr,
  input  logic [3:0]                 i_instr_len,
  input  logic                       i_fetch_ready,
  output logic                       o_fetch_valid,
  output logic [ADDRESS_WIDTH-1:0]   o_fetch_pc,
  output logic                       o_valid,
  output logic [MAX_INSTR_WIDTH-1:0] o_instr,
  output logic [3:0]                 o_instr_len,
  output logic [ADDRESS_WIDTH-1:0]   o_pc,
  input  logic                       i_ready,
  input  logic                       i_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic                       o_len_error
);

  iq_state_e                state, state_next;
  logic [ADDRESS_WIDTH-1:0] pending_pc, pending_pc_next;
  logic [ADDRESS_WIDTH-1:0] running_pc, running_pc_next;
  logic                     push, pop, flush;
  logic                     set_overflow, set_len_error;
  logic                     fifo_empty;
  iq_entry_t                wr_entry, head;

  assign wr_entry    = '{instr: i_instr, len: i_instr_len, pc: running_pc};
  assign o_valid     = !fifo_empty;
  assign o_instr     = head.instr;
  assign o_instr_len = head.len;
  assign o_pc        = head.pc;
  assign o_fetch_pc  = pending_pc;

  // Next-state, fetch handshake and push/pop decisions; a redirect overrides everything else.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next      = state;
    pending_pc_next = pending_pc;
    running_pc_next = running_pc;
    o_fetch_valid   = (state != RUN);
    pop             = o_valid && i_ready;
    push            = 1'b0;
    flush           = 1'b0;
    set_overflow    = 1'b0;
    set_len_error   = 1'b0;
    if (i_redirect_valid) begin
      flush           = 1'b1;
      pop             = 1'b0;
      state_next      = REDIRECT;
      pending_pc_next = i_redirect_pc;
      running_pc_next = i_redirect_pc;
    end else begin
      case (state)
        START, REDIRECT: begin
          // Results seen while waiting for the new PC are stale and ignored.
          if (i_fetch_ready) state_next = RUN;
        end
        RUN: begin
          if (i_valid) begin
            if (!len_legal(i_instr_len)) begin
              set_len_error = 1'b1;
            end else if (o_full && !pop) begin
              set_overflow = 1'b1;
            end else begin
              push            = 1'b1;
              running_pc_next = running_pc + ADDRESS_WIDTH'(i_instr_len);
            end
          end
        end
        default: state_next = START;
      endcase
    end
  end

  // State, PC tracking and sticky error flags; reset beats any redirect.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= START;
      pending_pc  <= RESET_PC;
      running_pc  <= RESET_PC;
      o_overflow  <= 1'b0;
      o_len_error <= 1'b0;
    end else begin
      state      <= state_next;
      pending_pc <= pending_pc_next;
      running_pc <= running_pc_next;
      if (set_overflow)  o_overflow  <= 1'b1;
      if (set_len_error) o_len_error <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(iq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (o_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based reference model checked every cycle.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       i_valid;
  logic [MAX_INSTR_WIDTH-1:0] i_instr;
  logic [3:0]                 i_instr_len;
  logic                       i_fetch_ready;
  logic                       o_fetch_valid;
  logic [ADDRESS_WIDTH-1:0]   o_fetch_pc;
  logic                       o_valid;
  logic [MAX_INSTR_WIDTH-1:0] o_instr;
  logic [3:0]                 o_instr_len;
  logic [ADDRESS_WIDTH-1:0]   o_pc;
  logic                       i_ready;
  logic                       i_redirect_valid;
  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc;
  logic                       o_full;
  logic                       o_overflow;
  logic                       o_len_error;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;
  int instr_seq = 0;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_valid          (i_valid),
    .i_instr          (i_instr),
    .i_instr_len      (i_instr_len),
    .i_fetch_ready    (i_fetch_ready),
    .o_fetch_valid    (o_fetch_valid),
    .o_fetch_pc       (o_fetch_pc),
    .o_valid          (o_valid),
    .o_instr          (o_instr),
    .o_instr_len      (o_instr_len),
    .o_pc             (o_pc),
    .i_ready          (i_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_full           (o_full),
    .o_overflow       (o_overflow),
    .o_len_error      (o_len_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched entries plus a "waiting for fetch" flag.
  typedef struct {
    logic [MAX_INSTR_WIDTH-1:0] instr;
    logic [3:0]                 len;
    logic [ADDRESS_WIDTH-1:0]   pc;
  } ent_t;

  ent_t                     mq[$];
  bit                       m_fetching;
  logic [ADDRESS_WIDTH-1:0] m_pending, m_running;
  bit                       m_ovf, m_lerr;

  always @(posedge clk) begin
    bit   pop_now;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_fetching = 1;
      m_pending  = '0;
      m_running  = '0;
      m_ovf      = 0;
      m_lerr     = 0;
    end else if (i_redirect_valid) begin
      mq.delete();
      m_fetching = 1;
      m_pending  = i_redirect_pc;
      m_running  = i_redirect_pc;
    end else begin
      pop_now = (mq.size() != 0) && i_ready;
      if (m_fetching) begin
        if (i_fetch_ready) m_fetching = 0;
        if (pop_now) void'(mq.pop_front());
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (i_valid) begin
          if (i_instr_len == 0 || i_instr_len > 4) m_lerr = 1;
          else if (mq.size() == DEPTH) m_ovf = 1;
          else begin
            e.instr = i_instr;
            e.len   = i_instr_len;
            e.pc    = m_running;
            mq.push_back(e);
            m_running = m_running + 32'(i_instr_len);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", 64'(o_valid), 64'(mq.size() != 0));
      check("o_full", 64'(o_full), 64'(mq.size() == DEPTH));
      check("o_fetch_valid", 64'(o_fetch_valid), 64'(m_fetching));
      check("o_fetch_pc", 64'(o_fetch_pc), 64'(m_pending));
      check("o_overflow", 64'(o_overflow), 64'(m_ovf));
      check("o_len_error", 64'(o_len_error), 64'(m_lerr));
      if (mq.size() != 0) begin
        check("o_pc", 64'(o_pc), 64'(mq[0].pc));
        check("o_instr", 64'(o_instr), 64'(mq[0].instr));
        check("o_instr_len", 64'(o_instr_len), 64'(mq[0].len));
      end
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic step(input logic v, input logic [3:0] len, input logic rdy);
    i_valid     = v;
    i_instr_len = len;
    i_instr     = 32'hC0DE_0000 + 32'(instr_seq);
    instr_seq++;
    i_ready     = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; i_valid = 0; i_instr = '0; i_instr_len = '0; i_fetch_ready = 1;
    i_ready = 0; i_redirect_valid = 0; i_redirect_pc = '0;
    repeat (2) begin @(negedge clk); #1; end
    chk_en = 1;

    // Reset state: START offering RESET_PC.
    check("rst_fetch_valid", 64'(o_fetch_valid), 64'd1);
    check("rst_fetch_pc", 64'(o_fetch_pc), 64'h0);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_flags", 64'({o_full, o_overflow, o_len_error}), 64'd0);

    reset = 0;
    step(0, 0, 1);
    check("run_fetch_valid", 64'(o_fetch_valid), 64'd0);

    // Lengths 4,2,4 with decode ready.
    step(1, 4, 1); check("pc_seq0", 64'(o_pc), 64'h0);
    step(1, 2, 1); check("pc_seq1", 64'(o_pc), 64'h4);
    step(1, 4, 1); check("pc_seq2", 64'(o_pc), 64'h6);
    step(0, 0, 1); check("drained", 64'(o_valid), 64'd0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 4; i++) step(1, 2, 0);
    check("full_after4", 64'(o_full), 64'd1);
    check("no_ovf_yet", 64'(o_overflow), 64'd0);
    step(1, 2, 0);
    check("ovf_set", 64'(o_overflow), 64'd1);
    check("head_after_ovf", 64'(o_pc), 64'hA);
    step(0, 0, 1);
    check("head_after_pop", 64'(o_pc), 64'hC);

    // Redirect with 3 queued and a same-cycle result.
    i_redirect_valid = 1; i_redirect_pc = 32'h100;
    step(1, 2, 1);
    i_redirect_valid = 0;
    check("redir_flush", 64'(o_valid), 64'd0);
    check("redir_fetch_pc", 64'(o_fetch_pc), 64'h100);
    check("redir_fetch_valid", 64'(o_fetch_valid), 64'd1);
    i_fetch_ready = 0;
    step(1, 4, 1); check("stale_drop", 64'(o_valid), 64'd0);
    i_fetch_ready = 1;
    step(1, 4, 1); check("xfer_drop", 64'(o_valid), 64'd0);
    step(1, 4, 0); check("redir_pc", 64'(o_pc), 64'h100);

    // Illegal lengths: 0 and 5.
    step(1, 0, 1);
    check("len0_err", 64'(o_len_error), 64'd1);
    check("len0_nopush", 64'(o_valid), 64'd0);
    step(1, 5, 0); check("len5_nopush", 64'(o_valid), 64'd0);
    step(1, 2, 0); check("pc_after_err", 64'(o_pc), 64'h104);
    step(0, 0, 1);

    // Address wrap.
    i_redirect_valid = 1; i_redirect_pc = 32'hFFFF_FFFE;
    step(0, 0, 0);
    i_redirect_valid = 0;
    step(0, 0, 0);
    step(1, 4, 1); check("pc_top", 64'(o_pc), 64'hFFFF_FFFE);
    step(1, 4, 1); check("pc_wrap", 64'(o_pc), 64'h2);

    // Reset beats a same-cycle redirect and discards contents.
    reset = 1; i_redirect_valid = 1; i_redirect_pc = 32'h200;
    step(1, 4, 0);
    reset = 0; i_redirect_valid = 0;
    check("mrst_o_valid", 64'(o_valid), 64'd0);
    check("mrst_fetch_pc", 64'(o_fetch_pc), 64'h0);
    check("mrst_flags", 64'({o_overflow, o_len_error}), 64'd0);
    step(0, 0, 0);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) step(1, 4, 0);
    step(1, 4, 1);
    check("full_pushpop_full", 64'(o_full), 64'd1);
    check("full_pushpop_ovf", 64'(o_overflow), 64'd0);
    check("full_pushpop_head", 64'(o_pc), 64'h4);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    check("final_empty", 64'(o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
